// File: rtl/logic_arb.sv
// Round-robin arbiter in front of a single shared bitwise logic unit.
// One request is granted per open acceptance window; its result is held until the downstream side takes it.
module logic_arb #(
  parameter int N = 4,
  parameter int D = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N-1:0]           i_req_valid,
  input  logic [2*N-1:0]         i_req_op,
  input  logic [N*D-1:0]         i_req_a,
  input  logic [N*D-1:0]         i_req_b,
  output logic [N-1:0]           o_req_ready,
  output logic                   o_rsp_valid,
  output logic [$clog2(N)-1:0]   o_rsp_id,
  output logic [D-1:0]           o_rsp_data,
  input  logic                   i_rsp_ready,
  output logic                   o_idle
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [D-1:0]    rsp_data_q, rsp_data_d;

  logic            any_vld;
  logic [IW-1:0]   grant;
  logic            window;
  logic            accept;
  logic [1:0]      sel_op;
  logic [D-1:0]    sel_a, sel_b;

  function automatic logic [D-1:0] exec_op(input logic [1:0] op,
                                           input logic [D-1:0] a,
                                           input logic [D-1:0] b);
    logic [D-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    logic [IW-1:0] r;
    if (g == IW'(N - 1)) r = '0;
    else                 r = g + IW'(1);
    return r;
  endfunction

  // Search from the pointer upward, wrapping at N-1, for the first valid requester.
  always_comb begin
    int idx;
    any_vld = 1'b0;
    grant   = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any_vld && i_req_valid[idx]) begin
        any_vld = 1'b1;
        grant   = idx[IW-1:0];
      end
    end
  end

  assign window = (state_q == S_IDLE) || i_rsp_ready;
  assign accept = window && any_vld;

  assign sel_op = i_req_op[grant*2 +: 2];
  assign sel_a  = i_req_a[grant*D +: D];
  assign sel_b  = i_req_b[grant*D +: D];

  // Ready is gated by reset so nothing is handshaken while the block is held in reset.
  always_comb begin
    o_req_ready = '0;
    if (accept && i_rst_n) o_req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      state_d    = S_RESP;
      ptr_d      = next_ptr(grant);
      rsp_id_d   = grant;
      rsp_data_d = exec_op(sel_op, sel_a, sel_b);
    end else if (state_q == S_RESP && i_rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  // Stage boundary: accepted request -> registered response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_idle      = (state_q == S_IDLE);

endmodule
